// File: rtl/shiftreg_cfg_loader.sv
// Serial loader for the static and dynamic chip configuration shift registers.
// Ports: CLK/RST (sync, active high); start/mode/abort plus stat_data/dyn_data
// in; signal_out, sel_stat, sel_dyn, latch_stat, latch_dyn, busy, done out.
module shiftreg_cfg_loader #(
    parameter int SIZESRSTAT  = 88,
    parameter int SIZESRDYN   = 16,
    parameter int N_WAIT_PRE  = 8,
    parameter int N_WAIT_POST = 20,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  abort,
    input  logic [SIZESRSTAT-1:0] stat_data,
    input  logic [SIZESRDYN-1:0]  dyn_data,
    output logic                  signal_out,
    output logic                  sel_stat,
    output logic                  sel_dyn,
    output logic                  latch_stat,
    output logic                  latch_dyn,
    output logic                  busy,
    output logic                  done
);

    localparam int MAX_SR = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
    localparam int MAX_WT = (N_WAIT_PRE > N_WAIT_POST) ? N_WAIT_PRE : N_WAIT_POST;
    localparam int MAXD   = (MAX_SR > MAX_WT) ? MAX_SR : MAX_WT;
    localparam int CW     = $clog2(MAXD);

    typedef enum logic [2:0] {
        IDLE, WAIT_PRE, SHIFT_STAT, LATCH_STAT,
        SHIFT_DYN, LATCH_DYN, WAIT_POST, DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic [SIZESRSTAT-1:0] stat_sr_q, stat_sr_d;
    logic [SIZESRDYN-1:0]  dyn_sr_q, dyn_sr_d;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        stat_sr_d = stat_sr_q;
        dyn_sr_d  = dyn_sr_q;
        unique case (state_q)
            IDLE: begin
                if (start && (mode != 2'b00) && !abort) begin
                    mode_d    = mode;
                    stat_sr_d = stat_data;
                    dyn_sr_d  = dyn_data;
                    state_d   = WAIT_PRE;
                end
            end
            WAIT_PRE: begin
                if (cnt_q == CW'(N_WAIT_PRE - 1))
                    state_d = mode_q[1] ? SHIFT_STAT : SHIFT_DYN;
            end
            SHIFT_STAT: begin
                // The outgoing bit always sits at one fixed end.
                stat_sr_d = MSB_FIRST ? {stat_sr_q[SIZESRSTAT-2:0], 1'b0}
                                      : {1'b0, stat_sr_q[SIZESRSTAT-1:1]};
                if (cnt_q == CW'(SIZESRSTAT - 1))
                    state_d = LATCH_STAT;
            end
            LATCH_STAT: begin
                state_d = mode_q[0] ? SHIFT_DYN : WAIT_POST;
            end
            SHIFT_DYN: begin
                dyn_sr_d = MSB_FIRST ? {dyn_sr_q[SIZESRDYN-2:0], 1'b0}
                                     : {1'b0, dyn_sr_q[SIZESRDYN-1:1]};
                if (cnt_q == CW'(SIZESRDYN - 1))
                    state_d = LATCH_DYN;
            end
            LATCH_DYN: begin
                state_d = WAIT_POST;
            end
            WAIT_POST: begin
                if (cnt_q == CW'(N_WAIT_POST - 1))
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((state_q != IDLE) && abort)
            state_d = IDLE;
        // Restart on every state entry; held at zero while idle.
        if ((state_d != state_q) || (state_q == IDLE))
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= '0;
            stat_sr_q <= '0;
            dyn_sr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            stat_sr_q <= stat_sr_d;
            dyn_sr_q  <= dyn_sr_d;
        end
    end

    logic stat_bit, dyn_bit;
    assign stat_bit = MSB_FIRST ? stat_sr_q[SIZESRSTAT-1] : stat_sr_q[0];
    assign dyn_bit  = MSB_FIRST ? dyn_sr_q[SIZESRDYN-1] : dyn_sr_q[0];

    assign sel_stat   = (state_q == SHIFT_STAT);
    assign sel_dyn    = (state_q == SHIFT_DYN);
    assign latch_stat = (state_q == LATCH_STAT);
    assign latch_dyn  = (state_q == LATCH_DYN);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign signal_out = (sel_stat & stat_bit) | (sel_dyn & dyn_bit);

endmodule
